// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: operands are cut into STAGES slices,
// one slice added per cycle, carry registered between slices, global-stall handshake.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NGRP = SW / BLK;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Group carries come from BLK-wide generate/propagate; bits inside a group
    // only need the group carry-in to form their sums.
    function automatic logic [SW:0] slice_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] s;
        logic          c_grp;
        logic          c_bit;
        logic          grp_g;
        logic          grp_p;
        p     = x ^ y;
        g     = x & y;
        s     = '0;
        c_grp = ci;
        for (int j = 0; j < NGRP; j++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                grp_g = g[j*BLK+i] | (p[j*BLK+i] & grp_g);
                grp_p = grp_p & p[j*BLK+i];
            end
            c_bit = c_grp;
            for (int i = 0; i < BLK; i++) begin
                s[j*BLK+i] = p[j*BLK+i] ^ c_bit;
                c_bit      = g[j*BLK+i] | (p[j*BLK+i] & c_bit);
            end
            c_grp = grp_g | (grp_p & c_grp);
        end
        return {c_grp, s};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : stg
            // Operand bits still to be added (this slice and above) and the
            // sum bits already finished (this slice and below).
            logic [WIDTH-gi*SW-1:0] a_cur;
            logic [WIDTH-gi*SW-1:0] bp_cur;
            logic                   c_cur;
            logic                   v_cur;
            logic [SW-1:0]          s_slice;
            logic                   c_slice;
            logic [(gi+1)*SW-1:0]   sum_acc;

            if (gi == 0) begin : g_src
                assign a_cur   = a;
                assign bp_cur  = sub ? ~b : b;
                assign c_cur   = sub ? 1'b1 : cin;
                assign v_cur   = in_valid;
                assign sum_acc = s_slice;
            end else begin : g_src
                assign a_cur   = stg[gi-1].g_reg.a_reg;
                assign bp_cur  = stg[gi-1].g_reg.bp_reg;
                assign c_cur   = stg[gi-1].g_reg.c_reg;
                assign v_cur   = stg[gi-1].g_reg.v_reg;
                assign sum_acc = {s_slice, stg[gi-1].g_reg.s_reg};
            end

            assign {c_slice, s_slice} = slice_add(a_cur[SW-1:0], bp_cur[SW-1:0], c_cur);

            if (gi < STAGES - 1) begin : g_reg
                logic                       v_reg;
                logic                       c_reg;
                logic [WIDTH-(gi+1)*SW-1:0] a_reg;
                logic [WIDTH-(gi+1)*SW-1:0] bp_reg;
                logic [(gi+1)*SW-1:0]       s_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_reg  <= 1'b0;
                        c_reg  <= 1'b0;
                        a_reg  <= '0;
                        bp_reg <= '0;
                        s_reg  <= '0;
                    end else if (adv) begin
                        v_reg  <= v_cur;
                        c_reg  <= c_slice;
                        a_reg  <= a_cur[WIDTH-gi*SW-1:SW];
                        bp_reg <= bp_cur[WIDTH-gi*SW-1:SW];
                        s_reg  <= sum_acc;
                    end
                end
            end else begin : g_out
                // Carry into the MSB recovered from its sum bit: s = p ^ c.
                logic c_msb;
                assign c_msb = a_cur[SW-1] ^ bp_cur[SW-1] ^ s_slice[SW-1];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        out_valid <= 1'b0;
                        sum       <= '0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        zero      <= 1'b0;
                    end else if (adv) begin
                        out_valid <= v_cur;
                        sum       <= sum_acc;
                        cout      <= c_slice;
                        ovf       <= c_slice ^ c_msb;
                        zero      <= (sum_acc == '0);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: table vectors, stall, mid-flight reset and a random
// stream, all checked through an expected-result queue.
module tb_cla_pipe_addsub;
    localparam int WIDTH  = 16;
    localparam int BLK    = 4;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    cla_pipe_addsub #(.WIDTH(WIDTH), .BLK(BLK), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          issue;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_on   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: wide integer add of the effective operands.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (ma[15] == bb[15]) && (full[15] != ma[15]);
        e.zero = (full[15:0] == 16'd0);
        e.issue = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, input exp_t e_in);
        exp_t e;
        e = e_in;
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 100) begin
                chk("send_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        e.issue = cyc;
        e.lat   = lat_on;
        q.push_back(e);
        $display("send a=%h b=%h cin=%0d sub=%0d exp sum=%h cout=%0d ovf=%0d zero=%0d",
                 ta, tb_v, tc, ts, e.sum, e.cout, e.ovf, e.zero);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [15:0] ta, input logic [15:0] tb_v,
                              input logic tc, input logic ts);
        send(ta, tb_v, tc, ts, model(ta, tb_v, tc, ts));
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                $display("recv sum=%h cout=%0d ovf=%0d zero=%0d (exp %h %0d %0d %0d) cycle %0d",
                         sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero, cyc);
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
                chk("zero", zero, e.zero);
                if (e.lat) chk("latency", cyc - e.issue, STAGES);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_sum;
        logic        held_cout;
        logic        held_ovf;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 32'd0);
        chk("reset_sum", sum, 32'd0);
        chk("reset_flags", {cout, ovf, zero}, 32'd0);
        chk("reset_in_ready", in_ready, 32'd1);
        @(posedge clk);
        #1;

        // Table vectors issued back-to-back; latency checked per result.
        lat_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.sum = vecs[i].sum; e.cout = vecs[i].cout;
            e.ovf = vecs[i].ovf; e.zero = vecs[i].zero;
            e.issue = 0; e.lat = 1'b0;
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
        end
        drain();

        // Downstream stall of three cycles starting when the first result shows.
        lat_on = 1'b0;
        fork
            begin
                send_model(16'h1111, 16'h2222, 1'b0, 1'b0);
                send_model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
                send_model(16'h0100, 16'h0200, 1'b0, 1'b1);
            end
            begin
                for (int n = 0; n < 50; n++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                chk("stall_first_valid", out_valid, 32'd1);
                out_ready = 1'b0;
                held_sum  = sum;
                held_cout = cout;
                held_ovf  = ovf;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 32'd0);
                    chk("stall_out_valid", out_valid, 32'd1);
                    chk("stall_hold_sum", sum, held_sum);
                    chk("stall_hold_flags", {cout, ovf}, {held_cout, held_ovf});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while results are in flight.
        lat_on = 1'b1;
        send_model(16'h1234, 16'h0001, 1'b0, 1'b0);
        send_model(16'h0001, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("prerst_out_valid", out_valid, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 32'd0);
        chk("rst_async_sum", sum, 32'd0);
        chk("rst_async_flags", {cout, ovf, zero}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", out_valid, 32'd0);
            chk("postrst_in_ready", in_ready, 32'd1);
        end
        @(posedge clk);
        #1;
        send_model(16'h4000, 16'h4000, 1'b0, 1'b0);
        drain();

        // Random stream with gaps and random backpressure.
        lat_on = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
